invaders_formation: RTL
=======================

# invaders_formation

Formation controller for the 20-invader block. Keeps the alive mask, the horizontal offset, the march direction and the descent line, and advances them once per step interval counted in video frames. The interval shortens as invaders die. It drives `invaders_array` and `invaders_line` directly into the gameplay state module, and it freezes whenever that module reports a state other than PLAYING.

## Interface
- `SCREEN_COLS`, default 16: playfield width in invader columns.
- `LAST_LINE`, default 13: descent line at which `invaders_line` saturates (the gameplay GAME_OVER line).
- `STEP_BASE`, default 1: frames added to the alive count to form the step period.
- `clk_36MHz` in, 1: system clock.
- `reset` in, 1: synchronous, active-low.
- `frame_tick` in, 1: one-cycle pulse per video frame.
- `hit_valid` in, 1: one-cycle pulse; the collision logic reports a bullet hit.
- `hit_index` in, 5: invader hit, encoded as row*5+col; rows 0..3, cols 0..4.
- `gameplay` in, 2: game state; 00 = PLAYING.
- `invaders_array` out, 20: alive mask; bit row*5+col.
- `invaders_line` out, 4: number of descents taken.
- `invaders_x` out, 5: biased offset; formation column c sits at screen column `invaders_x` + c − 4.
- `invaders_dir` out, 1: 1 = moving right.
- `step_pulse` out, 1: one-cycle pulse on every move or descent.
- `kill_pulse` out, 1: one-cycle pulse when a live invader is cleared.

## Operation
- Reset values: `invaders_array` = 20'hFFFFF, `invaders_line` = 0, `invaders_x` = 4, `invaders_dir` = 1, frame counter = 0, `step_pulse` = 0, `kill_pulse` = 0.
- Alive count: 5-bit popcount of `invaders_array`.
- Step period: `STEP_BASE` + alive count. With defaults this is 21 frames with 20 alive and 2 frames with 1 alive.
- Column limits:
  - lmin = lowest column with any alive bit in any row.
  - rmax = highest such column.
  - Both are derived combinationally from the registered array.
- Frame counter (5 bits): increments on each `frame_tick` while playing and not stepping.
- Step condition: on a `frame_tick` where counter + 1 ≥ period. When this holds, the counter clears to 0 and a step is taken. The ≥ compare covers the case where a hit shrinks the period below the current count.
- Step actions:
  - Right-edge case: if `invaders_dir` = 1 and `invaders_x` + rmax = `SCREEN_COLS` + 3, this is a descent. `invaders_line` increments, saturating at `LAST_LINE`, and `invaders_dir` flips to 0.
  - Left-edge case: if `invaders_dir` = 0 and `invaders_x` + lmin = 4, this is a descent. `invaders_line` increments, saturating at `LAST_LINE`, and `invaders_dir` flips to 1.
  - Otherwise `invaders_x` moves ±1 in the current direction.
  - `step_pulse` is asserted for every step, move or descent, including a saturated descent.
- Hits:
  - When `hit_valid` = 1, `hit_index` < 20 and that bit is set: the bit clears and `kill_pulse` asserts for one cycle.
  - `hit_index` ≥ 20, or an already-dead bit: ignored, no `kill_pulse`.
- Simultaneous hit and step: both are applied in the same cycle. The edge decision and period use the pre-hit (registered) array.
- Empty array: no steps. The counter holds and position, line and direction hold. Hits are ignored by definition.
- Freeze (`gameplay` ≠ 00):
  - Counter, position, line and direction hold; `step_pulse` = 0.
  - Hits are still ignored and `kill_pulse` = 0, so the mask is frozen for YOU_WIN/GAME_OVER.
- Reset mid-operation restores all reset values on the next edge regardless of other inputs.

## Timing
- All outputs are registered and update on the `clk_36MHz` edge that samples the triggering input.
- Latency: `frame_tick` or `hit_valid` at edge N → new outputs and pulses visible after edge N.
- `step_pulse` and `kill_pulse` are exactly one cycle wide. Back-to-back `hit_valid` pulses each produce their own `kill_pulse`.
- The gameplay module sees the updated array and line one cycle after this block's change.
- `frame_tick` is treated as a pulse. A tick held high for k cycles counts k frames; upstream guarantees single-cycle ticks.

## Test plan
- Reset then 21 ticks, full array → exactly one `step_pulse` on tick 21; `invaders_x` 4→5; line 0; dir 1.
- March right, full array, `SCREEN_COLS` = 16 → x reaches 15 after 11 steps. The 12th step is a descent: line = 1, dir = 0, x = 15. The next step gives x = 14.
- Clear columns 0..3 by hits (16 hits, 16 `kill_pulse`s; period becomes 5) → moving left, x goes down to 0, then the descent fires at x + lmin = 4.
- Hit `hit_index` = 7 twice, then 25 → bit 7 clears; exactly one `kill_pulse`; array = 20'hFFF7F.
- Hit coinciding with the step tick at the right edge, on a column-4 invader → descent is still taken based on the pre-hit rmax; bit cleared the same cycle.
- Drive line to 13, then more descents → line stays 13 and `step_pulse` is still emitted. Set `gameplay` = 10 → no steps, hits ignored. Then `reset` = 0 for one cycle → all outputs return to reset values.

Source files
------------

// File: rtl/invaders_formation.sv
// ---------------------------------------------------------------------------
// invaders_formation
//
// Formation controller for the 20-invader block (4 rows x 5 columns). It holds
// the alive mask, the horizontal offset, the march direction and the descent
// line. These advance once per step interval, which is counted in video frames
// and gets shorter as invaders die. All state freezes while the gameplay state
// is anything other than PLAYING.
//
// Parameters
//   SCREEN_COLS : playfield width in invader columns
//   LAST_LINE   : descent line at which invaders_line saturates
//   STEP_BASE   : frames added to the alive count to form the step period
//
// Ports
//   clk_36MHz      in   system clock
//   reset          in   synchronous, active-low reset
//   frame_tick     in   one-cycle pulse per video frame
//   hit_valid      in   one-cycle pulse, bullet hit reported
//   hit_index[4:0] in   hit invader, row*5+col
//   gameplay[1:0]  in   game state, 00 = PLAYING
//   invaders_array out  alive mask, bit row*5+col
//   invaders_line  out  number of descents taken (saturating)
//   invaders_x     out  biased offset; column c is at screen column x+c-4
//   invaders_dir   out  1 = moving right
//   step_pulse     out  one-cycle pulse per move or descent
//   kill_pulse     out  one-cycle pulse per live invader cleared
// ---------------------------------------------------------------------------
module invaders_formation #(
  parameter int SCREEN_COLS = 16,
  parameter int LAST_LINE   = 13,
  parameter int STEP_BASE   = 1
) (
  input  logic        clk_36MHz,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        hit_valid,
  input  logic [4:0]  hit_index,
  input  logic [1:0]  gameplay,
  output logic [19:0] invaders_array,
  output logic [3:0]  invaders_line,
  output logic [4:0]  invaders_x,
  output logic        invaders_dir,
  output logic        step_pulse,
  output logic        kill_pulse
);

  logic [19:0] array_q, array_d;
  logic [3:0]  line_q,  line_d;
  logic [4:0]  x_q,     x_d;
  logic        dir_q,   dir_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        step_q,  step_d;
  logic        kill_q,  kill_d;

  logic        playing;
  logic        empty;
  logic [4:0]  alive_cnt;
  logic [4:0]  col_any;
  logic [2:0]  lmin;
  logic [2:0]  rmax;
  logic [5:0]  period;
  logic [5:0]  cnt_next;
  logic        step_now;
  logic        at_right;
  logic        at_left;
  logic [19:0] hit_mask;
  logic        kill_now;

  assign playing = (gameplay == 2'b00);
  assign empty   = (array_q == 20'd0);

  always_comb begin
    alive_cnt = 5'd0;
    for (int i = 0; i < 20; i++) begin
      alive_cnt = alive_cnt + 5'(array_q[i]);
    end
  end

  always_comb begin
    col_any = 5'd0;
    for (int c = 0; c < 5; c++) begin
      col_any[c] = array_q[c] | array_q[c+5] | array_q[c+10] | array_q[c+15];
    end
  end

  // Scan from the far side so the last hit wins: lowest column for lmin,
  // highest for rmax. Both default to 0 when the array is empty, which is
  // harmless because an empty formation never steps.
  always_comb begin
    lmin = 3'd0;
    rmax = 3'd0;
    for (int c = 4; c >= 0; c--) begin
      if (col_any[c]) lmin = 3'(c);
    end
    for (int c = 0; c < 5; c++) begin
      if (col_any[c]) rmax = 3'(c);
    end
  end

  // Period and edge decisions use the registered array, so a hit landing on
  // the step tick does not change the step that is taken that cycle.
  assign period   = 6'(STEP_BASE) + {1'b0, alive_cnt};
  assign cnt_next = {1'b0, cnt_q} + 6'd1;
  // >= rather than == so a hit that shrinks the period below the running
  // count still steps on the next tick instead of wrapping.
  assign step_now = frame_tick & playing & ~empty & (cnt_next >= period);

  assign at_right = dir_q  & (({1'b0, x_q} + {3'b000, rmax}) == 6'(SCREEN_COLS + 3));
  assign at_left  = ~dir_q & (({1'b0, x_q} + {3'b000, lmin}) == 6'd4);

  // Out-of-range indices decode to an empty mask and are dropped.
  assign hit_mask = (hit_index < 5'd20) ? (20'd1 << hit_index) : 20'd0;
  assign kill_now = hit_valid & playing & (|(array_q & hit_mask));

  always_comb begin
    array_d = array_q;
    line_d  = line_q;
    x_d     = x_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    kill_d  = 1'b0;

    if (kill_now) begin
      array_d = array_q & ~hit_mask;
      kill_d  = 1'b1;
    end

    if (frame_tick && playing && !empty) begin
      if (step_now) begin
        cnt_d  = 5'd0;
        step_d = 1'b1;
        if (at_right || at_left) begin
          dir_d = ~dir_q;
          if (line_q < 4'(LAST_LINE)) begin
            line_d = line_q + 4'd1;
          end
        end else if (dir_q) begin
          x_d = x_q + 5'd1;
        end else begin
          x_d = x_q - 5'd1;
        end
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      array_q <= 20'hFFFFF;
      line_q  <= 4'd0;
      x_q     <= 5'd4;
      dir_q   <= 1'b1;
      cnt_q   <= 5'd0;
      step_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      array_q <= array_d;
      line_q  <= line_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      kill_q  <= kill_d;
    end
  end

  assign invaders_array = array_q;
  assign invaders_line  = line_q;
  assign invaders_x     = x_q;
  assign invaders_dir   = dir_q;
  assign step_pulse     = step_q;
  assign kill_pulse     = kill_q;

endmodule
